// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of a single-port data memory
// Optional: define ARB_TIMEOUT_EN to abort a grant after TIMEOUT cycles without mem_ready.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    grant,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_served, last_served_nxt;  // 0 = CPU served last, 1 = DMA
  logic   done;
  logic   timeout_hit;

  assign done = (state != IDLE) && (mem_ready || timeout_hit);

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] tmo_cnt;

  assign timeout_hit = (state != IDLE) && !mem_ready && (tmo_cnt == CW'(TIMEOUT - 1));
  assign err         = timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || done) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
    end
  end

  // Memory-side mux and ready/rdata routing depend only on the registered owner.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    grant           = 2'b00;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    cpu_ready       = 1'b0;
    dma_ready       = 1'b0;
    cpu_rdata       = '0;
    dma_rdata       = '0;
    case (state)
      IDLE: begin
        if (cpu_req && dma_req) begin
          state_nxt = last_served ? GNT_CPU : GNT_DMA;
        end else if (cpu_req) begin
          state_nxt = GNT_CPU;
        end else if (dma_req) begin
          state_nxt = GNT_DMA;
        end
      end
      GNT_CPU: begin
        grant     = 2'b01;
        mem_req   = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = done;
        cpu_rdata = timeout_hit ? '0 : mem_rdata;
        if (done) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b0;
        end
      end
      GNT_DMA: begin
        grant     = 2'b10;
        mem_req   = 1'b1;
        mem_we    = dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        dma_ready = done;
        dma_rdata = timeout_hit ? '0 : mem_rdata;
        if (done) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (model compare plus directed cases)
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
  localparam int TMO   = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TMO   = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk, reset;
  logic          cpu_req, cpu_we, cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ready;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    grant;
  logic          err;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .err(err)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Stimulus agents: requesters hold req until their ready handshake; memory answers after mem_lat cycles.
  int          cpu_todo, dma_todo, mem_lat, wcnt;
  bit          cpu_fire, dma_fire, stray, dma_seen;
  logic [DW-1:0] rd_val;

  always @(posedge clk) begin
    #1;
    if (cpu_fire) begin
      cpu_fire = 1'b0;
      if (cpu_todo > 0) cpu_todo--;
      if (cpu_todo == 0) cpu_req = 1'b0;
    end
    if (dma_fire) begin
      dma_fire = 1'b0;
      if (dma_todo > 0) dma_todo--;
      if (dma_todo == 0) dma_req = 1'b0;
    end
    if (reset) begin
      mem_ready = 1'b0; wcnt = 0; mem_rdata = 32'hA5A5_5A5A;
    end else if (mem_ready) begin
      mem_ready = 1'b0; wcnt = 0; mem_rdata = 32'hA5A5_5A5A;
    end else if (mem_req) begin
      if (wcnt >= mem_lat) begin
        mem_ready = 1'b1; mem_rdata = rd_val;
      end else begin
        wcnt++;
      end
    end else begin
      mem_ready = stray;
    end
  end

  // Model: owner 0 = none, 1 = CPU, 2 = DMA; last 1/2 = who was served last.
  int m_owner, m_last, m_gcnt;
  bit exp_done, exp_to;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_cpu_ready", 64'(cpu_ready), 64'(0));
      chk("rst_dma_ready", 64'(dma_ready), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      m_owner = 0; m_last = 2; m_gcnt = 0;
    end else begin
      exp_to   = (m_owner != 0) && !mem_ready && TO_EN && (m_gcnt == TMO - 1);
      exp_done = (m_owner != 0) && (mem_ready || exp_to);
      chk("grant", 64'(grant), 64'(m_owner == 1 ? 1 : (m_owner == 2 ? 2 : 0)));
      chk("mem_req", 64'(mem_req), 64'(m_owner != 0));
      if (m_owner == 0) chk("mem_we_idle", 64'(mem_we), 64'(0));
      if (m_owner == 1) begin
        chk("mem_we_cpu", 64'(mem_we), 64'(cpu_we));
        chk("mem_addr_cpu", 64'(mem_addr), 64'(cpu_addr));
        chk("mem_wdata_cpu", 64'(mem_wdata), 64'(cpu_wdata));
      end
      if (m_owner == 2) begin
        chk("mem_we_dma", 64'(mem_we), 64'(dma_we));
        chk("mem_addr_dma", 64'(mem_addr), 64'(dma_addr));
        chk("mem_wdata_dma", 64'(mem_wdata), 64'(dma_wdata));
      end
      chk("cpu_ready", 64'(cpu_ready), 64'(exp_done && m_owner == 1));
      chk("dma_ready", 64'(dma_ready), 64'(exp_done && m_owner == 2));
      if (m_owner != 1) chk("cpu_rdata_zero", 64'(cpu_rdata), 64'(0));
      else if (exp_done) chk("cpu_rdata", 64'(cpu_rdata), exp_to ? 64'(0) : 64'(mem_rdata));
      if (m_owner != 2) chk("dma_rdata_zero", 64'(dma_rdata), 64'(0));
      else if (exp_done) chk("dma_rdata", 64'(dma_rdata), exp_to ? 64'(0) : 64'(mem_rdata));
      chk("err", 64'(err), 64'(exp_to));
      if (cpu_ready) cpu_fire = 1'b1;
      if (dma_ready) begin dma_fire = 1'b1; dma_seen = 1'b1; end
      if (m_owner == 0) begin
        m_gcnt = 0;
        if (cpu_req && dma_req) m_owner = (m_last == 1) ? 2 : 1;
        else if (cpu_req) m_owner = 1;
        else if (dma_req) m_owner = 2;
      end else if (exp_done) begin
        m_last = m_owner; m_owner = 0; m_gcnt = 0;
      end else begin
        m_gcnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int ok;
    ok = 0;
    for (int i = 0; i < 20 && ok == 0; i++) begin
      @(negedge clk);
      if (grant == g) ok = 1;
    end
    chk("wait_grant", 64'(ok), 64'(1));
  endtask

  logic [1:0] seq [12];
  logic [1:0] exp_fair [12];
  logic [1:0] exp_dmaw [7];
  int         cnt, lat;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 0; mem_rdata = '0; rd_val = '0; mem_lat = 0; wcnt = 0;
    cpu_todo = 0; dma_todo = 0; cpu_fire = 0; dma_fire = 0; stray = 0; dma_seen = 0;
    exp_fair = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
    exp_dmaw = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
    #20 reset = 1'b0;

    // Idle after reset
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (grant == 2'b00 && !mem_req) cnt++;
    end
    chk("idle_after_reset", 64'(cnt), 64'(10));

    // Fairness: both requesters, three transactions each
    step(1);
    mem_lat = 0; rd_val = 32'h0000_1111;
    cpu_todo = 3; dma_todo = 3; cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seq[i] = grant; end
    for (int i = 0; i < 12; i++) chk($sformatf("fair_seq%0d", i), 64'(seq[i]), 64'(exp_fair[i]));
    step(3);

    // CPU-only read of 0x10
    cpu_addr = 32'h10; cpu_we = 0; rd_val = 32'hDEAD_BEEF; mem_lat = 0;
    cpu_todo = 1; cpu_req = 1;
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        lat = i;
        chk("cpu_rd_data", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);
        chk("cpu_rd_addr", 64'(mem_addr), 64'h10);
        chk("cpu_rd_dma_ready", 64'(dma_ready), 64'(0));
      end
    end
    chk("cpu_rd_latency", 64'(lat), 64'(2));
    step(3);

    // DMA write with 3-cycle memory delay while the CPU also requests
    dma_addr = 32'h40; dma_wdata = 32'h1234_5678; dma_we = 1;
    cpu_addr = 32'h80; cpu_we = 0; mem_lat = 3;
    dma_todo = 1; cpu_todo = 1; dma_req = 1; cpu_req = 1;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      seq[i] = grant;
      if (grant == 2'b10 && mem_addr == 32'h40 && mem_wdata == 32'h1234_5678 && mem_we) cnt++;
    end
    for (int i = 0; i < 7; i++) chk($sformatf("dmaw_seq%0d", i), 64'(seq[i]), 64'(exp_dmaw[i]));
    chk("dmaw_stable_cycles", 64'(cnt), 64'(4));
    step(8);
    dma_we = 0;

    // Stray mem_ready while idle must not produce any ready
    stray = 1; step(1); stray = 0; step(3);

    // Reset in the second GNT_DMA cycle
    mem_lat = 10; dma_addr = 32'h44; dma_seen = 0;
    dma_todo = 1; dma_req = 1;
    wait_grant(2'b10);
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("midrst_grant", 64'(grant), 64'(0));
    chk("midrst_mem_req", 64'(mem_req), 64'(0));
    chk("midrst_dma_ready", 64'(dma_ready), 64'(0));
    dma_req = 0; dma_todo = 0;
    step(2);
    reset = 0;
    chk("midrst_no_dma_ready", 64'(dma_seen), 64'(0));
    mem_lat = 0; cpu_todo = 1; dma_todo = 1; cpu_req = 1; dma_req = 1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); seq[i] = grant; end
    for (int i = 0; i < 4; i++) chk($sformatf("postrst_seq%0d", i), 64'(seq[i]), 64'(exp_fair[i]));
    step(3);

    // Memory never answers
    mem_lat = 100000; cpu_addr = 32'h20; cpu_todo = 1; cpu_req = 1;
    wait_grant(2'b01);
`ifdef ARB_TIMEOUT_EN
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      if (i > 1) @(negedge clk);
      if (cpu_ready) begin
        lat = i;
        chk("tmo_err", 64'(err), 64'(1));
        chk("tmo_rdata", 64'(cpu_rdata), 64'(0));
      end
    end
    chk("tmo_gnt_cycle", 64'(lat), 64'(4));
`else
    cnt = 0;
    for (int i = 0; i < 55; i++) begin
      @(negedge clk);
      if (grant == 2'b01 && mem_req && !err && !cpu_ready) cnt++;
    end
    chk("grant_persists", 64'(cnt), 64'(55));
`endif
    step(1);
    mem_lat = 0;
    step(4);
    chk("final_idle", 64'(grant), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the cycle limit for a granted transaction, used only with ARB_TIMEOUT_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port cpu_req, input, 1 bit: CPU load/store request, held until cpu_ready.
REQ-007 The block SHALL have ports cpu_we (input, 1), cpu_addr (input, AW) and cpu_wdata (input, DW): the CPU write enable, address and write data.
REQ-008 The block SHALL have ports cpu_rdata (output, DW) and cpu_ready (output, 1): CPU read data and completion pulse.
REQ-009 The block SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_rdata and dma_ready, with the same widths and meanings as the cpu_* ports, for the DMA/loader requester.
REQ-010 The block SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, DW): the request to the single-port data memory.
REQ-011 The block SHALL have ports mem_rdata (input, DW) and mem_ready (input, 1): memory read data and completion.
REQ-012 The block SHALL have port grant, output, 2 bits: one-hot owner, where bit0 is CPU, bit1 is DMA, and 00 is idle.
REQ-013 The block SHALL have port err, output, 1 bit: timeout pulse, tied 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, GNT_CPU and GNT_DMA, held in a registered state.
REQ-015 In IDLE with only one request asserted, the FSM SHALL move to that requester's GNT state on the next edge.
REQ-016 In IDLE with both requests asserted, the FSM SHALL grant the requester other than last_served; last_served is a 1-bit register that selects CPU first after reset.
REQ-017 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-018 In a GNT state, the block SHALL drive mem_req=1 and mux mem_we, mem_addr and mem_wdata from the owner, combinationally from the registered state.
REQ-019 In IDLE, the block SHALL drive mem_req=0 and mem_we=0.
REQ-020 In a GNT state with mem_ready=1, the owner's ready SHALL be 1 in that same cycle, its rdata SHALL equal mem_rdata, and the FSM SHALL go to IDLE next edge with last_served updated to the owner.
REQ-021 A non-owner's ready SHALL stay 0 and its rdata SHALL be 0.
REQ-022 The minimum transaction latency SHALL be 2 cycles from req to ready (1 grant cycle, then mem_ready in the first GNT cycle); back-to-back grants SHALL be separated by one IDLE cycle.
REQ-023 The grant SHALL never change while mem_ready is 0; the owner's req deasserting mid-grant is a protocol violation and SHALL be ignored.
REQ-024 mem_ready asserted while in IDLE SHALL be ignored.
REQ-025 Fairness: with both requesters continuously asserting req, grants SHALL alternate CPU, DMA, CPU, and so on.

Reset
REQ-026 When reset is asserted at any time, including mid-transaction, the block SHALL asynchronously force state=IDLE, last_served=DMA (so the CPU wins first), grant=00, mem_req=0, mem_we=0, cpu_ready=0, dma_ready=0, err=0, and timeout count=0.
REQ-027 An in-flight transaction SHALL be abandoned by reset without a ready pulse.
REQ-028 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge at which a req is sampled.

Configuration
REQ-029 With macro ARB_TIMEOUT_EN defined, a counter SHALL increment every GNT cycle without mem_ready, and when it reaches TIMEOUT-1 without mem_ready the block SHALL pulse the owner's ready and err for 1 cycle with rdata=0, then go to IDLE and update last_served.
REQ-030 With ARB_TIMEOUT_EN defined, the counter SHALL clear on entry to IDLE.
REQ-031 Without ARB_TIMEOUT_EN, no counter SHALL exist, err SHALL be constant 0, and a grant SHALL wait for mem_ready indefinitely.

Verification
REQ-032 The bench SHALL check reset held for 20 ns then released with no requests -> grant=00 and mem_req=0 for 10 cycles.
REQ-033 The bench SHALL check CPU-only read of addr 0x10 with the memory returning 0xDEADBEEF after 1 cycle -> cpu_ready 2 cycles after req with cpu_rdata=0xDEADBEEF, and dma_ready=0.
REQ-034 The bench SHALL check cpu_req and dma_req asserted together for 6 transactions -> grant order CPU, DMA, CPU, DMA, CPU, DMA with one IDLE cycle between each.
REQ-035 The bench SHALL check a DMA write of 0x12345678 to 0x40 with mem_ready delayed 3 cycles -> mem_addr, mem_wdata and mem_we stable for all 4 GNT cycles, and no CPU grant during that time although cpu_req=1.
REQ-036 The bench SHALL check reset asserted in the 2nd cycle of GNT_DMA -> immediate grant=00 and mem_req=0 with no dma_ready, and after release a simultaneous request is granted to the CPU first.
REQ-037 The bench SHALL check, with ARB_TIMEOUT_EN and TIMEOUT=4, that mem_ready held at 0 yields err and cpu_ready high together for 1 cycle, 4 cycles after the grant, with rdata=0; without the macro, the grant persists for more than 50 cycles.
